// File: rtl/led_arbiter.sv
module led_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LED_W          = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int HB_PERIOD      = 50000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LED_W-1:0]     pattern,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner_id,
  output logic                       busy,
  output logic [LED_W-1:0]           led_tri_o
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = $clog2(HB_PERIOD);

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HB_MAX  = HW'(HB_PERIOD - 1);
  localparam logic [OW-1:0] LAST_ID = OW'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t         state;
  logic [CW-1:0]  own_cnt;
  logic [HW-1:0]  hb_cnt;
  logic           hb_bit;

  logic [LED_W-1:0] hb_led;
  logic [LED_W-1:0] owner_pat;
  logic [OW-1:0]    winner;
  logic [OW-1:0]    cand;
  logic             any_req;
  logic             owner_req;
  logic             others_req;
  logic             timed_out;

  // Round-robin: scan from owner_id+1 upward with wrap; the last owner is
  // visited last, so it only wins again when nobody else is asking.
  always_comb begin
    winner  = owner_id;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = OW'((32'(owner_id) + k) % N_REQ);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    owner_pat = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (OW'(i) == owner_id) begin
        owner_pat = pattern[i*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    hb_led     = LED_W'(hb_bit);
    owner_req  = req[owner_id];
    // grant is onehot(owner_id) while in OWN, so masking with it leaves the
    // competing requesters only.
    others_req = |(req & ~grant);
    timed_out  = (own_cnt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      led_tri_o <= '0;
      owner_id  <= LAST_ID;
      own_cnt   <= '0;
      hb_cnt    <= '0;
      hb_bit    <= 1'b0;
    end else begin
      led_tri_o <= (state == OWN) ? owner_pat : hb_led;

      if (hb_cnt == HB_MAX) begin
        hb_cnt <= '0;
        hb_bit <= ~hb_bit;
      end else begin
        hb_cnt <= hb_cnt + HW'(1);
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= OWN;
            owner_id <= winner;
            grant    <= N_REQ'(1) << winner;
            busy     <= 1'b1;
            own_cnt  <= '0;
          end
        end
        OWN: begin
          if (!owner_req || (timed_out && others_req)) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else if (!timed_out) begin
            own_cnt <= own_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
